// File: rtl/elevator_controller_if.sv
// Dispatch-to-counter bundle: floor calls in, floor position back, step/direction and door status out.
interface elevator_controller_if #(
  parameter int unsigned N_FLOORS = 8,
  parameter int unsigned FLOOR_W  = 3
);
  logic [N_FLOORS-1:0] call_req;
  logic [FLOOR_W-1:0]  floor;
  logic                step;
  logic                up_down;
  logic                door_open;
  logic [N_FLOORS-1:0] pending;
  logic                busy;

  modport master (
    output call_req, floor,
    input  step, up_down, door_open, pending, busy
  );

  modport slave (
    input  call_req, floor,
    output step, up_down, door_open, pending, busy
  );
endinterface

// File: rtl/elevator_controller.sv
// SCAN elevator dispatcher: latches floor calls, pulses the floor counter toward them
// and sequences door dwell at each served floor.
module elevator_controller #(
  parameter int unsigned N_FLOORS      = 8,
  parameter int unsigned FLOOR_W       = 3,
  parameter int unsigned TRAVEL_CYCLES = 50,
  parameter int unsigned DOOR_CYCLES   = 100
) (
  input  logic                 clk,
  input  logic                 reset,
  elevator_controller_if.slave bus
);

  localparam int unsigned TMR_MAX = (TRAVEL_CYCLES > DOOR_CYCLES) ? TRAVEL_CYCLES : DOOR_CYCLES;
  localparam int unsigned TIMER_W = $clog2(TMR_MAX);
  localparam logic [TIMER_W-1:0] TRAVEL_LOAD = TIMER_W'(TRAVEL_CYCLES - 1);
  localparam logic [TIMER_W-1:0] DOOR_LOAD   = TIMER_W'(DOOR_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, MOVING, ARRIVE, DOOR_OPEN} state_t;

  state_t              state, state_n;
  logic [TIMER_W-1:0]  timer, timer_n;
  logic                up_down_r, up_down_n;
  logic [N_FLOORS-1:0] pending_r, pending_n;
  logic [N_FLOORS-1:0] floor_hot;
  logic                step_r, door_r, busy_r;
  logic                above, below, here, ahead, behind, recall;

  // Position of outstanding calls relative to the current floor.
  always_comb begin : call_flags
    above     = 1'b0;
    below     = 1'b0;
    here      = 1'b0;
    floor_hot = '0;
    for (int unsigned i = 0; i < N_FLOORS; i++) begin
      floor_hot[i] = (FLOOR_W'(i) == bus.floor);
      if (pending_r[i]) begin
        if (FLOOR_W'(i) > bus.floor) above = 1'b1;
        if (FLOOR_W'(i) < bus.floor) below = 1'b1;
        if (floor_hot[i])            here  = 1'b1;
      end
    end
    ahead  = up_down_r ? above : below;
    behind = up_down_r ? below : above;
    recall = |(bus.call_req & floor_hot);
  end

  always_comb begin : next_state
    state_n   = state;
    timer_n   = timer;
    up_down_n = up_down_r;
    case (state)
      IDLE: begin
        if (here) begin
          state_n = DOOR_OPEN;
          timer_n = DOOR_LOAD;
        end else if (ahead) begin
          state_n = MOVING;
          timer_n = TRAVEL_LOAD;
        end else if (behind) begin
          state_n   = MOVING;
          timer_n   = TRAVEL_LOAD;
          up_down_n = ~up_down_r;
        end
      end
      MOVING: begin
        if (timer == '0) state_n = ARRIVE;
        else             timer_n = timer - TIMER_W'(1);
      end
      ARRIVE: begin
        if (here) begin
          state_n = DOOR_OPEN;
          timer_n = DOOR_LOAD;
        end else if (ahead) begin
          state_n = MOVING;
          timer_n = TRAVEL_LOAD;
        end else begin
          state_n = IDLE;
        end
      end
      DOOR_OPEN: begin
        // A fresh call at this floor holds the door rather than being latched.
        if (recall)             timer_n = DOOR_LOAD;
        else if (timer == '0)   state_n = IDLE;
        else                    timer_n = timer - TIMER_W'(1);
      end
      default: state_n = IDLE;
    endcase
    pending_n = (pending_r | bus.call_req)
              & ~(((state == DOOR_OPEN) || (state_n == DOOR_OPEN)) ? floor_hot : '0);
  end

  always_ff @(posedge clk) begin : regs
    if (reset) begin
      state     <= IDLE;
      timer     <= '0;
      up_down_r <= 1'b1;
      pending_r <= '0;
      step_r    <= 1'b0;
      door_r    <= 1'b0;
      busy_r    <= 1'b0;
    end else begin
      state     <= state_n;
      timer     <= timer_n;
      up_down_r <= up_down_n;
      pending_r <= pending_n;
      step_r    <= (state_n == MOVING) && (timer_n == '0);
      door_r    <= (state_n == DOOR_OPEN);
      busy_r    <= (state_n != IDLE);
    end
  end

  assign bus.step      = step_r;
  assign bus.up_down   = up_down_r;
  assign bus.door_open = door_r;
  assign bus.pending   = pending_r;
  assign bus.busy      = busy_r;

endmodule

// File: tb/tb_elevator_controller.sv
// Bench for elevator_controller: procedural SCAN model plus directed stops, a dwell restart,
// a mid-move reset and a random call soak, with the floor counter modelled here.
module tb_elevator_controller;
  localparam int unsigned N  = 8;
  localparam int unsigned W  = 3;
  localparam int          TC = 4;
  localparam int          DC = 3;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  elevator_controller_if #(.N_FLOORS(N), .FLOOR_W(W)) bus();

  elevator_controller #(
    .N_FLOORS(N), .FLOOR_W(W), .TRAVEL_CYCLES(TC), .DOOR_CYCLES(DC)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  // Floor counter downstream of the dispatcher.
  always @(posedge clk) begin
    if (reset)         bus.floor <= '0;
    else if (bus.step) bus.floor <= bus.up_down ? bus.floor + W'(1) : bus.floor - W'(1);
  end

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int step_q[$];
  int door_len_q[$];
  int door_rise_q[$];
  int door_floor_q[$];
  logic prev_door = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  function automatic logic [N-1:0] bit_of(input int f);
    logic [N-1:0] v;
    v = '0;
    v[f] = 1'b1;
    return v;
  endfunction

  // ---------------- behavioural model ----------------
  logic [N-1:0] m_pending = '0;
  logic [N-1:0] m_last_call = '0;
  logic [W-1:0] m_floor = '0;
  logic         m_dir = 1'b1;
  logic         m_rst = 1'b0;

  function automatic void eval(output logic h, output logic a, output logic b);
    int f;
    logic [N-1:0] lower;
    logic up, dn;
    f     = int'(m_floor);
    lower = N'((32'd1 << f) - 32'd1);
    up    = ((m_pending >> (f + 1)) != '0);
    dn    = ((m_pending & lower) != '0);
    h     = m_pending[m_floor];
    a     = m_dir ? up : dn;
    b     = m_dir ? dn : up;
  endfunction

  // One clock of the model: check this cycle's outputs, then apply the edge.
  task automatic tick(input logic e_step, input logic e_door, input logic e_busy, input logic e_clr);
    logic [N-1:0] hot;
    @(negedge clk);
    chk("step", 32'(bus.step), 32'(e_step));
    chk("door_open", 32'(bus.door_open), 32'(e_door));
    chk("busy", 32'(bus.busy), 32'(e_busy));
    chk("up_down", 32'(bus.up_down), 32'(m_dir));
    chk("pending", 32'(bus.pending), 32'(m_pending));
    chk("floor", 32'(bus.floor), 32'(m_floor));
    if (bus.step === 1'b1) begin
      chk("step_top_bound", 32'(bus.up_down && (bus.floor == W'(N - 1))), 32'd0);
      chk("step_bottom_bound", 32'(!bus.up_down && (bus.floor == '0)), 32'd0);
      chk("step_door_overlap", 32'(bus.door_open), 32'd0);
      step_q.push_back(cyc);
    end
    if (bus.door_open === 1'b1) begin
      if (!prev_door) begin
        door_len_q.push_back(1);
        door_rise_q.push_back(cyc);
        door_floor_q.push_back(int'(bus.floor));
      end else begin
        door_len_q[door_len_q.size() - 1] = door_len_q[door_len_q.size() - 1] + 1;
      end
    end
    prev_door = (bus.door_open === 1'b1);
    @(posedge clk);
    m_last_call = bus.call_req;
    if (reset) begin
      m_pending = '0;
      m_floor   = '0;
      m_dir     = 1'b1;
      m_rst     = 1'b1;
    end else begin
      hot = '0;
      hot[m_floor] = 1'b1;
      m_pending = (m_pending | m_last_call) & (e_clr ? ~hot : '1);
      if (e_step) m_floor = m_dir ? m_floor + W'(1) : m_floor - W'(1);
    end
  endtask

  task automatic dwell();
    int left;
    left = DC;
    while (left > 0) begin
      tick(1'b0, 1'b1, 1'b1, 1'b1);
      if (m_rst) return;
      if (m_last_call[m_floor]) left = DC;
      else left--;
    end
  endtask

  task automatic travel();
    logic h, a, b;
    forever begin
      for (int k = 0; k < TC; k++) begin
        tick(k == TC - 1, 1'b0, 1'b1, 1'b0);
        if (m_rst) return;
      end
      eval(h, a, b);
      if (h) begin
        tick(1'b0, 1'b0, 1'b1, 1'b1);
        if (m_rst) return;
        dwell();
        return;
      end
      tick(1'b0, 1'b0, 1'b1, 1'b0);
      if (m_rst || !a) return;
    end
  endtask

  // One pass starting from an idle decision cycle.
  task automatic model_pass();
    logic h, a, b;
    eval(h, a, b);
    if (h) begin
      tick(1'b0, 1'b0, 1'b0, 1'b1);
      if (m_rst) return;
      dwell();
    end else if (a) begin
      tick(1'b0, 1'b0, 1'b0, 1'b0);
      if (m_rst) return;
      travel();
    end else if (b) begin
      tick(1'b0, 1'b0, 1'b0, 1'b0);
      if (m_rst) return;
      m_dir = ~m_dir;
      travel();
    end else begin
      tick(1'b0, 1'b0, 1'b0, 1'b0);
    end
  endtask

  initial begin : model
    repeat (2) @(posedge clk);
    forever begin
      m_rst = 1'b0;
      model_pass();
    end
  end

  // ---------------- stimulus ----------------
  int call_cyc;

  task automatic pulse(input logic [N-1:0] m);
    @(negedge clk);
    bus.call_req = m;
    call_cyc = cyc;
    @(negedge clk);
    bus.call_req = '0;
  endtask

  task automatic wait_idle(input int bound);
    int n;
    n = 0;
    @(negedge clk);
    while ((bus.busy !== 1'b0 || bus.pending !== '0) && n < bound) begin
      @(negedge clk);
      n++;
    end
    chk("idle_timeout", 32'(n >= bound), 32'd0);
  endtask

  task automatic clear_logs();
    step_q.delete();
    door_len_q.delete();
    door_rise_q.delete();
    door_floor_q.delete();
  endtask

  initial begin : stim
    int n;
    bus.call_req = '0;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    // reset state
    @(negedge clk);
    chk("rst_pending", 32'(bus.pending), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_up_down", 32'(bus.up_down), 32'd1);
    chk("rst_door", 32'(bus.door_open), 32'd0);
    chk("rst_step", 32'(bus.step), 32'd0);

    // call at the current floor
    clear_logs();
    pulse(bit_of(0));
    wait_idle(100);
    chk("here_door_count", 32'(door_rise_q.size()), 32'd1);
    chk("here_door_latency", 32'(door_rise_q[0] - call_cyc), 32'd2);
    chk("here_door_len", 32'(door_len_q[0]), 32'd3);
    chk("here_no_step", 32'(step_q.size()), 32'd0);

    // climb three floors
    clear_logs();
    pulse(bit_of(3));
    wait_idle(200);
    chk("up3_steps", 32'(step_q.size()), 32'd3);
    chk("up3_first_step", 32'(step_q[0] - call_cyc), 32'd5);
    chk("up3_gap1", 32'(step_q[1] - step_q[0]), 32'd5);
    chk("up3_gap2", 32'(step_q[2] - step_q[1]), 32'd5);
    chk("up3_floor", 32'(bus.floor), 32'd3);
    chk("up3_door_len", 32'(door_len_q[0]), 32'd3);
    chk("up3_door_floor", 32'(door_floor_q[0]), 32'd3);

    // reverse down to 2, then sweep up to 5 with calls at 1 and 4 arriving en route
    pulse(bit_of(2));
    wait_idle(200);
    chk("down2_floor", 32'(bus.floor), 32'd2);
    chk("down2_dir", 32'(bus.up_down), 32'd0);
    clear_logs();
    pulse(bit_of(5));
    pulse(bit_of(1) | bit_of(4));
    wait_idle(400);
    chk("scan_stops", 32'(door_floor_q.size()), 32'd3);
    chk("scan_stop0", 32'(door_floor_q[0]), 32'd4);
    chk("scan_stop1", 32'(door_floor_q[1]), 32'd5);
    chk("scan_stop2", 32'(door_floor_q[2]), 32'd1);
    chk("scan_floor", 32'(bus.floor), 32'd1);
    chk("scan_dir", 32'(bus.up_down), 32'd0);

    // dwell restart at floor 4, re-pulse in the second door cycle
    clear_logs();
    pulse(bit_of(4));
    n = 0;
    while (bus.door_open !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("dwell_wait_timeout", 32'(n >= 100), 32'd0);
    @(negedge clk);
    bus.call_req = bit_of(4);
    @(negedge clk);
    bus.call_req = '0;
    wait_idle(100);
    chk("dwell_runs", 32'(door_len_q.size()), 32'd1);
    chk("dwell_len", 32'(door_len_q[0]), 32'd5);
    chk("dwell_floor", 32'(bus.floor), 32'd4);

    // reset in the third travel cycle toward floor 7
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    clear_logs();
    pulse(bit_of(7));
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    chk("mid_busy", 32'(bus.busy), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("mid_rst_busy", 32'(bus.busy), 32'd0);
    chk("mid_rst_pending", 32'(bus.pending), 32'd0);
    chk("mid_rst_step", 32'(bus.step), 32'd0);
    chk("mid_rst_up_down", 32'(bus.up_down), 32'd1);
    chk("mid_rst_floor", 32'(bus.floor), 32'd0);
    chk("mid_rst_no_step", 32'(step_q.size()), 32'd0);

    // random call soak
    for (int i = 0; i < 10000; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 15) == 0) bus.call_req = bit_of(int'($urandom_range(0, N - 1)));
      else bus.call_req = '0;
    end
    @(negedge clk);
    bus.call_req = '0;
    wait_idle(3000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "watchdog expired");
  end

endmodule
